// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a 256 x 16 synchronous single-port memory shared by
// an instruction-fetch port (read-only) and a load/store port (read/write).
module mem_access_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ready,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_ls;
    logic              r_sel_ls;
    logic              r_we;
    logic              r_oor;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_if_valid;
    logic              r_ls_valid;
    logic              r_if_err;
    logic              r_ls_err;

    logic              w_idle;
    logic              w_access;
    logic              w_wait;
    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_grant;
    logic              w_if_oor;
    logic              w_ls_oor;
    logic [DATA_W-1:0] w_rd_data;

    assign w_idle   = (r_state == S_IDLE);
    assign w_access = (r_state == S_ACCESS);
    assign w_wait   = (r_state == S_WAIT);

    // LS has priority except right after an LS grant, so contention alternates.
    assign w_grant_if = w_idle & if_req & (~ls_req | r_last_ls);
    assign w_grant_ls = w_idle & ls_req & ~w_grant_if;
    assign w_grant    = w_grant_if | w_grant_ls;

    assign w_if_oor  = |if_addr[ADDR_W-1:DEPTH_BITS];
    assign w_ls_oor  = |ls_addr[ADDR_W-1:DEPTH_BITS];
    assign w_rd_data = r_oor ? '0 : mem_rdata;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= w_grant ? S_ACCESS : S_IDLE;
                S_ACCESS: r_state <= S_WAIT;
                S_WAIT:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_ls <= 1'b0;
            r_sel_ls  <= 1'b0;
            r_we      <= 1'b0;
            r_oor     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (w_grant) begin
            r_last_ls <= w_grant_ls;
            r_sel_ls  <= w_grant_ls;
            r_we      <= w_grant_ls & ls_we;
            r_oor     <= w_grant_ls ? w_ls_oor : w_if_oor;
            r_addr    <= w_grant_ls ? ls_addr : if_addr;
            if (w_grant_ls) begin
                r_wdata <= ls_wdata;
            end
        end
    end

    // Responses: the memory's registered data_out is valid in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_ls_valid <= 1'b0;
            r_if_err   <= 1'b0;
            r_ls_err   <= 1'b0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else begin
            r_if_valid <= w_wait & ~r_sel_ls;
            r_ls_valid <= w_wait & r_sel_ls;
            r_if_err   <= w_wait & ~r_sel_ls & r_oor;
            r_ls_err   <= w_wait & r_sel_ls & r_oor;
            if (w_wait && !r_sel_ls) begin
                r_if_rdata <= w_rd_data;
            end
            if (w_wait && r_sel_ls && !r_we) begin
                r_ls_rdata <= w_rd_data;
            end
        end
    end

    assign if_ready  = w_grant_if;
    assign ls_ready  = w_grant_ls;
    assign if_valid  = r_if_valid;
    assign ls_valid  = r_ls_valid;
    assign if_err    = r_if_err;
    assign ls_err    = r_ls_err;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_re    = w_access & ~r_we & ~r_oor;
    assign mem_we    = w_access & r_we & r_sel_ls & ~r_oor;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural 256x16 RAM, reference memory
// and a response scoreboard filled at grant time and drained on valid pulses.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ready;
    logic        if_valid;
    logic [15:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [15:0] ls_wdata;
    logic        ls_ready;
    logic        ls_valid;
    logic [15:0] ls_rdata;
    logic        ls_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_ready  (ls_ready),
        .ls_valid  (ls_valid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ls;
        logic [15:0] rdata;
        bit          err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] ram     [0:255];
    logic [15:0] ref_mem [0:255];
    bit          ram_init = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          strobes = 0;
    int          exp_strobes = 0;
    logic [15:0] exp_ls_rdata = 16'h0000;

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 16'h0101) ^ 16'h5A5A;
    endfunction

    // Single-port synchronous RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
            ram_init <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called on the cycle whose closing edge grants the request.
    task automatic push_exp(input bit is_ls, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata);
        exp_t e;
        bit   oor = (addr[15:8] != 8'h00);
        e.is_ls = is_ls;
        e.err   = oor;
        e.due   = cyc + 3;
        if (is_ls && we) begin
            if (!oor) ref_mem[addr[7:0]] = wdata;
            e.rdata = exp_ls_rdata;
        end else begin
            e.rdata = oor ? 16'h0000 : ref_mem[addr[7:0]];
            if (is_ls) exp_ls_rdata = e.rdata;
        end
        if (!oor) exp_strobes++;
        sb.push_back(e);
    endtask

    // Returns at the negedge of the ACCESS cycle with the request already dropped.
    task automatic issue(input bit is_ls, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit track);
        bit got = 1'b0;
        @(negedge clk);
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 0; k < 20; k++) begin
            #1;
            if (is_ls ? ls_ready : if_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("grant_timeout", 32'd0, 32'd1);
        else if (track) push_exp(is_ls, we, addr, wdata);
        @(negedge clk);
        if (is_ls) ls_req = 1'b0;
        else       if_req = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            strobes++;
            check("strobe_excl", 32'(mem_we & mem_re), 32'd0);
            check("strobe_range", 32'(mem_addr[15:8]), 32'd0);
        end
        if (if_valid || ls_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'({if_valid, ls_valid}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_port", 32'({if_valid, ls_valid}), mon_e.is_ls ? 32'd1 : 32'd2);
                check("resp_rdata", 32'(mon_e.is_ls ? ls_rdata : if_rdata), 32'(mon_e.rdata));
                check("resp_err", 32'(mon_e.is_ls ? ls_err : if_err), 32'(mon_e.err));
                check("resp_latency", 32'(cyc), 32'(mon_e.due));
            end
        end else if (if_err || ls_err) begin
            check("stray_err", 32'({if_err, ls_err}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int gport [0:3];
    int gcyc  [0:3];
    int ng;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;

        // Reset values, then a fetch presented as reset is released.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 32'({if_ready, if_valid, if_err, ls_ready, ls_valid, ls_err, mem_we, mem_re}), 32'd0);
        check("rst_rdata", 32'({if_rdata, ls_rdata}), 32'd0);
        check("rst_mem", 32'({mem_addr, mem_wdata}), 32'd0);
        rst = 1'b0; if_req = 1'b1; if_addr = 16'h0005;
        #1;
        check("first_if_ready", 32'({if_ready, ls_ready}), 32'd2);
        push_exp(1'b0, 1'b0, 16'h0005, 16'h0000);
        @(negedge clk);
        if_req = 1'b0;

        // Store then load.
        issue(1'b1, 1'b1, 16'h00A3, 16'hBEEF, 1'b1);
        check("wr_strobe", 32'({mem_we, mem_re}), 32'd2);
        check("wr_addr", 32'(mem_addr), 32'h00A3);
        check("wr_data", 32'(mem_wdata), 32'hBEEF);
        @(negedge clk);
        check("wr_one_cycle", 32'(mem_we), 32'd0);
        issue(1'b1, 1'b0, 16'h00A3, 16'h0000, 1'b1);
        check("rd_strobe", 32'({mem_we, mem_re}), 32'd1);

        // Out-of-range accesses.
        issue(1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1);
        check("oor_wr_no_strobe", 32'({mem_we, mem_re}), 32'd0);
        issue(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
        issue(1'b0, 1'b0, 16'hFF00, 16'h0000, 1'b1);
        check("oor_if_no_strobe", 32'({mem_we, mem_re}), 32'd0);
        issue(1'b0, 1'b0, 16'h0042, 16'h0000, 1'b1);
        drain();

        // Reset during the ACCESS cycle of a read.
        issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        exp_strobes++;
        check("mid_rst_re_before", 32'(mem_re), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ctrl", 32'({if_valid, ls_valid, if_err, ls_err, mem_we, mem_re}), 32'd0);
        check("mid_rst_regs", 32'({if_rdata, ls_rdata}), 32'd0);
        check("mid_rst_mem", 32'({mem_addr, mem_wdata}), 32'd0);
        rst = 1'b0;
        exp_ls_rdata = 16'h0000;
        repeat (4) @(negedge clk);

        // IF request pulsed for one cycle while LS owns the port.
        issue(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1);
        if_req = 1'b1; if_addr = 16'h0077;
        #1;
        check("drop_no_ready", 32'(if_ready), 32'd0);
        @(negedge clk);
        if_req = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        // Continuous contention from reset: LS, IF, LS, IF, three cycles apart.
        rst = 1'b1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h00A3;
        if_req = 1'b1; if_addr = 16'h0005;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_ls_rdata = 16'h0000;
        ng = 0;
        for (int k = 0; k < 20 && ng < 4; k++) begin
            #1;
            if (if_ready && ls_ready) check("cont_one_ready", 32'd2, 32'd1);
            if (ls_ready) begin
                gport[ng] = 1; gcyc[ng] = cyc; ng++;
                push_exp(1'b1, 1'b0, 16'h00A3, 16'h0000);
            end else if (if_ready) begin
                gport[ng] = 0; gcyc[ng] = cyc; ng++;
                push_exp(1'b0, 1'b0, 16'h0005, 16'h0000);
            end
            @(negedge clk);
        end
        ls_req = 1'b0; if_req = 1'b0;
        check("cont_grants", 32'(ng), 32'd4);
        for (int k = 0; k < ng; k++) begin
            check("cont_order", 32'(gport[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k > 0) check("cont_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
        end
        drain();

        check("strobe_count", 32'(strobes), 32'(exp_strobes));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side controller for the 256-word × 16-bit synchronous single-port program/data memory. Two requesters share that one port:

- **Instruction fetch (IF):** read-only.
- **Load/store (LS):** read or write.

The block arbitrates between them, drives the memory's address, data, write-enable and read-enable inputs, and absorbs the memory's one-cycle registered read latency. It returns read data and write acknowledges to each requester with a one-cycle valid pulse.

## Interface

Parameters:
- `DATA_W`, 16, word width.
- `ADDR_W`, 16, address bus width.
- `DEPTH_BITS`, 8, implemented address bits; legal addresses are 0 to 2^DEPTH_BITS−1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock; all state changes on its rising edge.
  - `rst`  in  1  synchronous, active-high reset.
- Instruction fetch port:
  - `if_req`  in  1  fetch request; held with `if_addr` stable until accepted.
  - `if_addr`  in  ADDR_W  fetch address.
  - `if_ready`  out  1  fetch accepted this cycle when high together with `if_req`.
  - `if_valid`  out  1  one-cycle pulse; `if_rdata` holds the fetched word.
  - `if_rdata`  out  DATA_W  last fetched word (registered).
- Load/store port:
  - `ls_req`  in  1  load/store request; held with `ls_we`, `ls_addr`, `ls_wdata` stable until accepted.
  - `ls_we`  in  1  1 = write, 0 = read.
  - `ls_addr`  in  ADDR_W  load/store address.
  - `ls_wdata`  in  DATA_W  store data.
  - `ls_ready`  out  1  load/store accepted this cycle when high together with `ls_req`.
  - `ls_valid`  out  1  one-cycle pulse: load data valid, or write acknowledge.
  - `ls_rdata`  out  DATA_W  last loaded word (registered); unchanged by writes.
  - `ls_err`  out  1  pulses with `ls_valid` for an out-of-range access.
  - `if_err`  out  1  pulses with `if_valid` for an out-of-range access.
- Memory side:
  - `mem_addr`  out  ADDR_W  to the memory `address` input.
  - `mem_wdata`  out  DATA_W  to the memory `data_in` input.
  - `mem_we`  out  1  to the memory `write_enable` input.
  - `mem_re`  out  1  to the memory `read_enable` input.
  - `mem_rdata`  in  DATA_W  from the memory `data_out` output.

## Operation

- FSM states: IDLE, ACCESS, WAIT.
- IDLE:
  - At most one of `if_ready`/`ls_ready` is high. Each is combinational from state, both requests and `last_ls`.
  - Arbitration: LS wins, unless `last_ls`=1 and `if_req`=1, in which case IF wins. Continuous contention therefore alternates grants.
  - On a grant with its req high: latch port ID, address, `we`, wdata and the range check; set `last_ls` to the granted port; go to ACCESS.
- ACCESS:
  - Drive `mem_addr`/`mem_wdata` from the latched values.
  - Assert `mem_re` for a read, or `mem_we` for a write, only if the address is in range (`addr[ADDR_W-1:DEPTH_BITS]`==0).
  - Go to WAIT.
- WAIT:
  - Strobes are low.
  - At the next edge:
    - For an in-range read, load `mem_rdata` into the granted port's rdata register.
    - For an out-of-range read, load 0.
  - Pulse that port's valid, plus err if out of range, for the following cycle. Go to IDLE.
- Out-of-range write: `mem_we` never asserted; memory is unchanged; the ack is still returned with `ls_err`=1.
- IF requests are always reads; no path drives `mem_we` from the IF port.
- A request deasserted before it is granted is dropped without side effects.
- Reset (any state, including mid-access):
  - Next cycle: state IDLE; `mem_we`, `mem_re`, all valid and err outputs 0; `if_rdata`, `ls_rdata`, `mem_addr`, `mem_wdata` 0; `last_ls`=0.
  - An in-flight access produces no valid pulse.

## Timing

- Request accepted at edge E:
  - Memory strobe high during E..E+1; the memory acts at E+1.
  - rdata loaded and valid high during E+2..E+3.
- Latency is 2 cycles from acceptance to valid. Throughput is one access per 3 cycles, because the next grant is possible at edge E+3.
- Ready is 0 in ACCESS and WAIT, so requests wait.
- Valid and ready may be high in the same cycle. A new grant in that cycle is legal and independent of the response.
- `mem_re` and `mem_we` are never both high. Neither is ever high for more than one cycle per access.

## Test plan

- **Reset values:** assert `rst` for 2 cycles → all outputs 0. Release `rst` with `if_req`=1, `if_addr`=0x0005 → `if_ready`=1 in the first cycle after reset.
- **Store then load:**
  - LS write 0x00A3 ← 0xBEEF → `mem_we`=1 for exactly one cycle with `mem_addr`=0x00A3; `ls_valid` at E+2 with `ls_err`=0.
  - Then LS read 0x00A3 → `ls_rdata`=0xBEEF and `ls_valid` high one cycle at E+2.
- **Contention:** `if_req` and `ls_req` held continuously from reset → grants ordered LS, IF, LS, IF; each grant 3 cycles apart.
- **Out of range:**
  - LS write 0x0100 ← 0x1234 → `mem_we` stays 0; `ls_valid`=`ls_err`=1.
  - Then read 0x0000 → returns its prior contents.
  - IF read 0xFF00 → `if_rdata`=0, `if_err`=1.
- **Reset mid-access:** `rst` asserted in the ACCESS cycle of a read → no `if_valid`/`ls_valid` pulse; IDLE with `mem_re`=0 the cycle after.
- **Dropped request:** `if_req` pulsed for 1 cycle while LS owns the port → no IF access is issued and no `if_valid` is produced.
